// File: rtl/serial_pkg.sv
// Shared definitions for the serial link: transmitter FSM encoding and the
// default frame geometry used by both the transmit and receive ends.
package serial_pkg;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

  localparam int DEFAULT_DATA_W       = 8;
  localparam int DEFAULT_CLKS_PER_BIT = 4;

endpackage

// File: rtl/baud_tick.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 while enabled and pulses tick on
// the last cycle of each bit. Held at zero whenever en is low.
module baud_tick #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int                CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0]  LAST  = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || !en) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = en && (cnt == LAST);

endmodule

// File: rtl/serial_tx.sv
// Serial transmitter: start bit, DATA_W data bits LSB first, one stop bit,
// each bit held CLKS_PER_BIT cycles on a registered, idle-high line.
module serial_tx
  import serial_pkg::*;
#(
  parameter int DATA_W       = DEFAULT_DATA_W,
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tx_valid,
  input  logic [DATA_W-1:0] tx_data,
  output logic              tx_ready,
  output logic              tx,
  output logic              busy,
  output tx_state_t         state_dbg
);

  localparam int               BIT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);

  tx_state_t         state, state_n;
  logic [BIT_W-1:0]  bit_idx, bit_idx_n;
  logic [DATA_W-1:0] shreg, shreg_n;
  logic              tx_n;
  logic              tick;

  // Handshake: a word transfers in any cycle where tx_valid && tx_ready;
  // tx_ready is only high in IDLE outside reset, so the producer may hold
  // tx_valid high and the next word is taken right after the stop bit.
  assign tx_ready  = (state == IDLE) && !rst;
  assign state_dbg = state;

  baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk  (clk),
    .rst  (rst),
    .en   (busy),
    .tick (tick)
  );

  always_comb begin
    state_n   = state;
    bit_idx_n = bit_idx;
    shreg_n   = shreg;
    case (state)
      IDLE: begin
        if (tx_valid && tx_ready) begin
          state_n   = START;
          shreg_n   = tx_data;
          bit_idx_n = '0;
        end
      end
      START: begin
        if (tick) begin
          state_n   = DATA;
          bit_idx_n = '0;
        end
      end
      DATA: begin
        if (tick) begin
          shreg_n = shreg >> 1;
          if (bit_idx == LAST_BIT) begin
            state_n = STOP;
          end else begin
            bit_idx_n = bit_idx + 1'b1;
          end
        end
      end
      STOP: begin
        if (tick) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase

    // The line is registered, so it is driven from the state being entered.
    case (state_n)
      START:   tx_n = 1'b0;
      DATA:    tx_n = shreg_n[0];
      default: tx_n = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      bit_idx <= '0;
      shreg   <= '0;
      tx      <= 1'b1;
      busy    <= 1'b0;
    end else begin
      state   <= state_n;
      bit_idx <= bit_idx_n;
      shreg   <= shreg_n;
      tx      <= tx_n;
      busy    <= (state_n != IDLE);
    end
  end

endmodule

// File: tb/tb_serial_tx.sv
// Directed bench for serial_tx: default geometry plus a DATA_W=5,
// CLKS_PER_BIT=2 instance, with hand-computed frame patterns.
module tb_serial_tx;
  import serial_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready, tx, busy;
  tx_state_t  state_dbg;

  logic       rst2;
  logic       tx_valid2;
  logic [4:0] tx_data2;
  logic       tx_ready2, tx2, busy2;
  tx_state_t  state_dbg2;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  serial_tx dut (
    .clk(clk), .rst(rst), .tx_valid(tx_valid), .tx_data(tx_data),
    .tx_ready(tx_ready), .tx(tx), .busy(busy), .state_dbg(state_dbg)
  );

  serial_tx #(.DATA_W(5), .CLKS_PER_BIT(2)) dut_small (
    .clk(clk), .rst(rst2), .tx_valid(tx_valid2), .tx_data(tx_data2),
    .tx_ready(tx_ready2), .tx(tx2), .busy(busy2), .state_dbg(state_dbg2)
  );

  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;  // bit 0 is the start bit, bit 9 the stop bit
    bit         poke;
  } vec_t;

  vec_t vecs[5];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic send(input logic [7:0] d);
    tx_data  = d;
    tx_valid = 1'b1;
    chk("ready_at_xfer", tx_ready, 1);
    step();
    tx_valid = 1'b0;
  endtask

  // Checks 40 frame cycles starting just after the transfer edge, then the
  // first cycle back in IDLE. With poke set, the inputs are disturbed mid-DATA.
  task automatic check_frame(input logic [9:0] f, input bit poke);
    tx_state_t es;
    for (int b = 0; b < 10; b++) begin
      for (int c = 0; c < 4; c++) begin
        if (poke && b == 4 && c == 0) begin
          tx_data  = 8'hFF;
          tx_valid = 1'b1;
        end
        es = (b == 0) ? START : ((b == 9) ? STOP : DATA);
        chk("frame_tx", tx, f[b]);
        chk("frame_busy", busy, 1);
        chk("frame_ready", tx_ready, 0);
        chk("frame_state", state_dbg, es);
        step();
      end
    end
    chk("end_ready", tx_ready, 1);
    chk("end_busy", busy, 0);
    chk("end_tx", tx, 1);
  endtask

  initial begin
    vecs[0] = '{data: 8'hA5, frame: 10'b1_10100101_0, poke: 1'b0};
    vecs[1] = '{data: 8'h3C, frame: 10'b1_00111100_0, poke: 1'b1};
    vecs[2] = '{data: 8'h81, frame: 10'b1_10000001_0, poke: 1'b0};
    vecs[3] = '{data: 8'h5A, frame: 10'b1_01011010_0, poke: 1'b0};
    vecs[4] = '{data: 8'h01, frame: 10'b1_00000001_0, poke: 1'b0};

    // Reset held with tx_valid high: nothing may start.
    rst = 1'b1; tx_valid = 1'b1; tx_data = 8'hA5;
    rst2 = 1'b1; tx_valid2 = 1'b0; tx_data2 = 5'h00;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_tx", tx, 1);
      chk("rst_busy", busy, 0);
      chk("rst_ready", tx_ready, 0);
      chk("rst_state", state_dbg, IDLE);
    end
    rst = 1'b0; rst2 = 1'b0; tx_valid = 1'b0;
    #1;
    chk("post_rst_ready", tx_ready, 1);
    chk("post_rst_ready2", tx_ready2, 1);
    step();
    chk("post_rst_busy", busy, 0);
    chk("post_rst_tx", tx, 1);

    // Table of single frames, one idle cycle between them.
    for (int i = 0; i < 5; i++) begin
      send(vecs[i].data);
      check_frame(vecs[i].frame, vecs[i].poke);
      tx_valid = 1'b0;
      step();
      chk("gap_busy", busy, 0);
    end

    // Back-to-back with tx_valid held: exactly one idle-high cycle between frames.
    tx_data = 8'h00; tx_valid = 1'b1;
    chk("b2b_ready", tx_ready, 1);
    step();
    tx_data = 8'hFF;
    check_frame(10'b1_00000000_0, 1'b0);
    step();
    check_frame(10'b1_11111111_0, 1'b0);
    tx_valid = 1'b0;
    step();
    chk("b2b_no_third", busy, 0);

    // Reset two cycles into data bit 3, then a clean frame.
    send(8'hC3);
    for (int b = 0; b < 4; b++) begin
      for (int c = 0; c < 4; c++) begin
        chk("pre_rst_tx", tx, (b == 0) ? 1'b0 : ((8'hC3 >> (b - 1)) & 1));
        step();
      end
    end
    chk("bit3_tx", tx, 0);
    step();
    rst = 1'b1;
    step();
    chk("midrst_tx", tx, 1);
    chk("midrst_busy", busy, 0);
    chk("midrst_ready", tx_ready, 0);
    chk("midrst_state", state_dbg, IDLE);
    rst = 1'b0;
    #1;
    chk("midrst_ready_after", tx_ready, 1);
    send(8'h81);
    check_frame(10'b1_10000001_0, 1'b0);
    step();

    // Narrow instance: 5'h13 -> 0, 1,1,0,0,1, 1 at two cycles per bit.
    tx_data2 = 5'h13; tx_valid2 = 1'b1;
    chk("small_ready", tx_ready2, 1);
    step();
    tx_valid2 = 1'b0;
    for (int b = 0; b < 7; b++) begin
      for (int c = 0; c < 2; c++) begin
        chk("small_tx", tx2, (7'b1_10011_0 >> b) & 1);
        chk("small_busy", busy2, 1);
        chk("small_ready_low", tx_ready2, 0);
        step();
      end
    end
    chk("small_end_ready", tx_ready2, 1);
    chk("small_end_busy", busy2, 0);
    chk("small_end_tx", tx2, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
